// File: rtl/segre_pkg.sv
// Shared types and constants for the segre in-order pipeline.
// Holds word/address widths, the canonical NOP encoding and the IF stage FSM states.
// No logic; imported by pipeline stage modules.
package segre_pkg;

  localparam int WORD_SIZE = 32;
  localparam int ADDR_SIZE = 32;

  // addi x0, x0, 0
  localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_KILL = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

endpackage

// File: rtl/segre_if_stage.sv
// Instruction-fetch stage: owns the PC, issues one instruction read at a time, registers IF/ID.
// Latency: read completed at cycle N is visible on instr_o/valid_id_o at N+1 (1 instr/cycle at 0 wait).
// Backpressure: block_if_i holds IF/ID and PC (a completed read is parked in a one-entry buffer);
//   inject_nops_i bubbles IF/ID and refetches; tkbr_i redirects, killing any read in flight.
// Ports: clk_i/rsn_i (sync active-low reset); mem_rd_o/mem_addr_o/mem_data_i/mem_ready_i memory side;
//   tkbr_i/new_pc_i redirect from EX; block_if_i/inject_nops_i hazard control; instr_o/pc_o/valid_id_o to ID.
module segre_if_stage
  import segre_pkg::*;
#(
  parameter logic [ADDR_SIZE-1:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  output logic                 mem_rd_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  input  logic [WORD_SIZE-1:0] mem_data_i,
  input  logic                 mem_ready_i,
  input  logic                 tkbr_i,
  input  logic [ADDR_SIZE-1:0] new_pc_i,
  input  logic                 block_if_i,
  input  logic                 inject_nops_i,
  output logic [WORD_SIZE-1:0] instr_o,
  output logic [ADDR_SIZE-1:0] pc_o,
  output logic                 valid_id_o
);

  if_state_e            state_q, state_d;
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic [ADDR_SIZE-1:0] pend_pc_q, pend_pc_d;
  logic [WORD_SIZE-1:0] buf_q, buf_d;
  logic [ADDR_SIZE-1:0] buf_pc_q, buf_pc_d;
  logic [WORD_SIZE-1:0] instr_q, instr_d;
  logic [ADDR_SIZE-1:0] pc_id_q, pc_id_d;
  logic                 valid_q, valid_d;

  // Redirect targets are forced word aligned.
  logic [ADDR_SIZE-1:0] new_pc;
  assign new_pc = new_pc_i & ~ADDR_SIZE'(3);

  // A read stays requested (on the same address) until the memory completes it, including in KILL.
  assign mem_rd_o   = (state_q == IF_REQ) || (state_q == IF_KILL);
  assign mem_addr_o = pc_q;

  assign instr_o    = instr_q;
  assign pc_o       = pc_id_q;
  assign valid_id_o = valid_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    buf_d     = buf_q;
    buf_pc_d  = buf_pc_q;

    // IF/ID default: hold while ID is stalled, otherwise a bubble. Only the load paths
    // below override this, and they are reachable only with block_if_i low.
    pc_id_d = pc_id_q;
    if (block_if_i) begin
      instr_d = instr_q;
      valid_d = valid_q;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

    case (state_q)
      IF_IDLE: begin
        state_d = IF_REQ;
      end

      IF_REQ: begin
        if (mem_ready_i) begin
          if (tkbr_i) begin
            pc_d = new_pc;
          end else if (block_if_i) begin
            // ID cannot take it yet: park the word so the read is not repeated.
            buf_d    = mem_data_i;
            buf_pc_d = pc_q;
            state_d  = IF_HOLD;
          end else if (!inject_nops_i) begin
            instr_d = mem_data_i;
            pc_id_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_SIZE'(4);
          end
          // inject only: bubble and refetch the same PC.
        end else if (tkbr_i) begin
          // Cannot abandon the read in flight; remember the target and drain it.
          pend_pc_d = new_pc;
          state_d   = IF_KILL;
        end
      end

      IF_KILL: begin
        if (mem_ready_i) begin
          pc_d    = tkbr_i ? new_pc : pend_pc_q;
          state_d = IF_REQ;
        end else if (tkbr_i) begin
          pend_pc_d = new_pc;
        end
      end

      IF_HOLD: begin
        if (tkbr_i) begin
          pc_d    = new_pc;
          state_d = IF_REQ;
        end else if (!block_if_i) begin
          state_d = IF_REQ;
          if (inject_nops_i) begin
            pc_d = buf_pc_q;
          end else begin
            instr_d = buf_q;
            pc_id_d = buf_pc_q;
            valid_d = 1'b1;
            pc_d    = buf_pc_q + ADDR_SIZE'(4);
          end
        end
      end

      default: begin
        state_d = IF_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q   <= IF_IDLE;
      pc_q      <= BOOT_ADDR;
      pend_pc_q <= '0;
      buf_q     <= '0;
      buf_pc_q  <= '0;
      instr_q   <= NOP_INSTR;
      pc_id_q   <= BOOT_ADDR;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      buf_q     <= buf_d;
      buf_pc_q  <= buf_pc_d;
      instr_q   <= instr_d;
      pc_id_q   <= pc_id_d;
      valid_q   <= valid_d;
    end
  end

endmodule
